// File: rtl/mem_pkg.sv
// mem_pkg: shared request-type constants and port FSM state type for mem_responder.
package mem_pkg;
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  typedef enum logic {IDLE, BUSY} mem_state_t;
endpackage

// File: rtl/mem_responder_port.sv
// mem_responder_port: wait-state FSM for one memory port; done marks the completing cycle.
module mem_responder_port
  import mem_pkg::*;
#(
  parameter int LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_val,
  output logic o_wait,
  output logic o_done
);
  localparam logic [3:0] L = 4'(LAT);
  mem_state_t r_state, w_state_nx;
  logic [3:0] r_cnt, w_cnt_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
  // done is masked during reset so a LAT=0 request cannot write or count while rst is held
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    o_wait     = 1'b0;
    o_done     = 1'b0;
    if (r_state == IDLE) begin
      if (i_val && L == 4'd0) begin
        o_done = !rst;
      end else if (i_val) begin
        o_wait     = 1'b1;
        w_state_nx = BUSY;
        w_cnt_nx   = 4'd1;
      end
    end else if (!i_val) begin
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
    end else if (r_cnt < L) begin
      o_wait   = 1'b1;
      w_cnt_nx = r_cnt + 4'd1;
    end else begin
      o_done     = !rst;
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
    end
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: shared word array serving an imem read port and a dmem read/write port
// with independent wait-state latencies, a backdoor loader and completion counters.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WORDS    = 256,
  parameter int IMEM_LAT = 0,
  parameter int DMEM_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_val,
  output logic        imem_wait,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  input  logic        dmem_val,
  output logic        dmem_wait,
  input  logic        dmem_type,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] imem_count,
  output logic [31:0] dmem_count
);
  localparam int AW = $clog2(WORDS);
  logic [31:0] r_mem [WORDS];
  logic [31:0] r_imem_count, r_dmem_count;
  logic [AW-1:0] w_iidx, w_didx, w_lidx;
  logic w_idone, w_ddone, w_dwr, w_unused;
  assign w_iidx   = imem_addr[AW+1:2];
  assign w_didx   = dmem_addr[AW+1:2];
  assign w_lidx   = load_addr[AW+1:2];
  assign w_unused = ^{imem_addr, dmem_addr, load_addr};
  mem_responder_port #(.LAT(IMEM_LAT)) u_iport (
    .clk(clk), .rst(rst), .i_val(imem_val), .o_wait(imem_wait), .o_done(w_idone)
  );
  mem_responder_port #(.LAT(DMEM_LAT)) u_dport (
    .clk(clk), .rst(rst), .i_val(dmem_val), .o_wait(dmem_wait), .o_done(w_ddone)
  );
  assign w_dwr = w_ddone && dmem_type == MEM_WRITE;
  // dmem write is issued last so it wins a same-word collision with the loader
  always_ff @(posedge clk) begin
    if (load_en && !rst) r_mem[w_lidx] <= load_data;
    if (w_dwr) r_mem[w_didx] <= dmem_wdata;
  end
  assign imem_rdata = w_idone ? r_mem[w_iidx] : '0;
  assign dmem_rdata = (w_ddone && dmem_type == MEM_READ) ? r_mem[w_didx] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_imem_count <= '0;
      r_dmem_count <= '0;
    end else begin
      r_imem_count <= r_imem_count + 32'(w_idone);
      r_dmem_count <= r_dmem_count + 32'(w_ddone);
    end
  end
  assign imem_count = r_imem_count;
  assign dmem_count = r_dmem_count;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench over two configurations (A: imem 0 / dmem 3, B: imem 4 / dmem 0).
module tb_mem_responder;
  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;
  logic clk = 1'b0;
  logic rst;
  logic iv[2], dv[2], dt[2], le[2], iw[2], dw[2];
  logic [31:0] ia[2], da[2], dwd[2], la[2], ld[2], ird[2], drd[2], ic[2], dc[2];
  logic [31:0] sq[4][$];
  chk_t cq[$];
  chk_t c;
  bit done = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mem_responder #(.WORDS(256), .IMEM_LAT(0), .DMEM_LAT(3)) dut_a (
    .clk(clk), .rst(rst),
    .imem_val(iv[0]), .imem_wait(iw[0]), .imem_addr(ia[0]), .imem_rdata(ird[0]),
    .dmem_val(dv[0]), .dmem_wait(dw[0]), .dmem_type(dt[0]), .dmem_addr(da[0]),
    .dmem_wdata(dwd[0]), .dmem_rdata(drd[0]),
    .load_en(le[0]), .load_addr(la[0]), .load_data(ld[0]),
    .imem_count(ic[0]), .dmem_count(dc[0])
  );
  mem_responder #(.WORDS(256), .IMEM_LAT(4), .DMEM_LAT(0)) dut_b (
    .clk(clk), .rst(rst),
    .imem_val(iv[1]), .imem_wait(iw[1]), .imem_addr(ia[1]), .imem_rdata(ird[1]),
    .dmem_val(dv[1]), .dmem_wait(dw[1]), .dmem_type(dt[1]), .dmem_addr(da[1]),
    .dmem_wdata(dwd[1]), .dmem_rdata(drd[1]),
    .load_en(le[1]), .load_addr(la[1]), .load_data(ld[1]),
    .imem_count(ic[1]), .dmem_count(dc[1])
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cq.push_back('{n, a, e});
  endtask
  task automatic ireq(input int k, input logic v, input logic [31:0] a);
    iv[k] = v;
    ia[k] = a;
  endtask
  task automatic dreq(input int k, input logic v, input logic t, input logic [31:0] a, input logic [31:0] w);
    dv[k]  = v;
    dt[k]  = t;
    da[k]  = a;
    dwd[k] = w;
  endtask
  task automatic load(input int k, input logic [31:0] a, input logic [31:0] d);
    le[k] = 1'b1;
    la[k] = a;
    ld[k] = d;
    tick();
    le[k] = 1'b0;
  endtask
  task automatic waits(input int k, input bit dm, input int n, input string nm);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", nm, i), 32'(dm ? dw[k] : iw[k]), (i < n) ? 32'd1 : 32'd0);
      tick();
    end
  endtask
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic pop(input int i, input logic [31:0] a, input string n);
    if (sq[i].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected completion, got %h expected none", n, a);
    end else cmp(n, a, sq[i].pop_front());
  endtask
  always @(negedge clk) begin
    while (cq.size() > 0) begin
      c = cq.pop_front();
      cmp(c.name, c.act, c.exp);
    end
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (iv[k] && !iw[k]) pop(2 * k, ird[k], $sformatf("imem_rdata%0d", k));
        if (dv[k] && !dw[k]) pop(2 * k + 1, drd[k], $sformatf("dmem_rdata%0d", k));
      end
    end
    if (done) begin
      for (int k = 0; k < 4; k++) cmp($sformatf("sb_empty%0d", k), 32'(sq[k].size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end
  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ireq(k, 1'b0, '0);
      dreq(k, 1'b0, 1'b0, '0, '0);
      le[k] = 1'b0;
      la[k] = '0;
      ld[k] = '0;
    end
    repeat (2) tick();
    @(negedge clk);
    chk("rst_icount_a", ic[0], 32'd0);
    chk("rst_dcount_a", dc[0], 32'd0);
    chk("rst_iwait_a", 32'(iw[0]), 32'd0);
    chk("rst_irdata_a", ird[0], 32'd0);
    chk("rst_drdata_a", drd[0], 32'd0);
    tick();
    rst = 1'b0;
    load(0, 32'h10, 32'hDEADBEEF);
    ireq(0, 1'b1, 32'h10);
    sq[0].push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("lat0_iwait", 32'(iw[0]), 32'd0);
    tick();
    ireq(0, 1'b0, '0);
    @(negedge clk);
    chk("lat0_icount", ic[0], 32'd1);
    tick();
    dreq(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    sq[1].push_back(32'h0);
    waits(0, 1'b1, 3, "dlat3_wr_wait");
    dreq(0, 1'b1, 1'b0, 32'h20, '0);
    sq[1].push_back(32'h12345678);
    waits(0, 1'b1, 3, "dlat3_rd_wait");
    dreq(0, 1'b0, 1'b0, '0, '0);
    load(0, 32'h400, 32'hCAFEF00D);
    ireq(0, 1'b1, 32'h1);
    sq[0].push_back(32'hCAFEF00D);
    tick();
    ireq(0, 1'b1, 32'h400);
    sq[0].push_back(32'hCAFEF00D);
    tick();
    ireq(0, 1'b0, '0);
    load(0, 32'h40, 32'h11111111);
    dreq(0, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5);
    sq[1].push_back(32'h0);
    repeat (3) tick();
    ireq(0, 1'b1, 32'h40);
    sq[0].push_back(32'h11111111);
    @(negedge clk);
    chk("coll_dwait", 32'(dw[0]), 32'd0);
    tick();
    dreq(0, 1'b0, 1'b0, '0, '0);
    sq[0].push_back(32'hA5A5A5A5);
    tick();
    ireq(0, 1'b0, '0);
    load(0, 32'h60, 32'h600D0001);
    dreq(0, 1'b1, 1'b1, 32'h60, 32'hBAD0BAD0);
    repeat (2) tick();
    dreq(0, 1'b0, 1'b1, 32'h60, 32'hBAD0BAD0);
    tick();
    @(negedge clk);
    chk("wd_dcount", dc[0], 32'd3);
    tick();
    dreq(0, 1'b1, 1'b0, 32'h60, '0);
    sq[1].push_back(32'h600D0001);
    waits(0, 1'b1, 3, "wd_rd_wait");
    dreq(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("a_icount", ic[0], 32'd5);
    chk("a_dcount", dc[0], 32'd4);
    tick();
    le[1] = 1'b1;
    la[1] = 32'h80;
    ld[1] = 32'hBBBBBBBB;
    dreq(1, 1'b1, 1'b1, 32'h80, 32'h77777777);
    sq[3].push_back(32'h0);
    tick();
    le[1] = 1'b0;
    dreq(1, 1'b1, 1'b0, 32'h80, '0);
    sq[3].push_back(32'h77777777);
    tick();
    dreq(1, 1'b0, 1'b0, '0, '0);
    load(1, 32'h84, 32'h5);
    load(1, 32'h08, 32'h0000ABCD);
    ireq(1, 1'b1, 32'h08);
    sq[2].push_back(32'h0000ABCD);
    repeat (2) tick();
    rst = 1'b1;
    le[1] = 1'b1;
    la[1] = 32'h84;
    ld[1] = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rst_mid_iwait", 32'(iw[1]), 32'd1);
    chk("rst_mid_icount", ic[1], 32'd0);
    chk("rst_mid_dcount", dc[1], 32'd0);
    tick();
    le[1] = 1'b0;
    rst = 1'b0;
    waits(1, 1'b0, 4, "rst_restart_wait");
    ireq(1, 1'b0, '0);
    @(negedge clk);
    chk("rst_icount1", ic[1], 32'd1);
    tick();
    dreq(1, 1'b1, 1'b0, 32'h84, '0);
    sq[3].push_back(32'h5);
    tick();
    dreq(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("b_dcount", dc[1], 32'd1);
    tick();
    done = 1'b1;
  end
endmodule
